// File: rtl/sram_like_arbiter_pkg.sv
// Shared encodings for the two-to-one sram-like arbiter: FSM states,
// transaction owner and transfer size codes.
package sram_like_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b11
    } state_t;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    // Bit positions inside the one-hot grant vector
    localparam int GNT_INST = 0;
    localparam int GNT_DATA = 1;

    function automatic owner_t grant_to_owner(input logic [1:0] grant);
        return grant[GNT_DATA] ? OWN_DATA : OWN_INST;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_rr_arb2.sv
// Two-input round-robin grant: one-hot grant while grant_en is high,
// with the tie-break side flipping to the loser after every grant.
module sram_like_arbiter_rr_arb2
    import sram_like_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic [1:0] grant
);

    owner_t prio_r;

    // Grant selection: a lone request wins outright, a tie goes to prio_r
    always_comb begin
        grant = 2'b00;
        if (!grant_en) begin
            grant = 2'b00;
        end else if (req == 2'b11) begin
            grant = (prio_r == OWN_DATA) ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
    end

    // Tie-break flop; after reset the data side wins the first tie
    always_ff @(posedge clk) begin
        if (!resetn) begin
            prio_r <= OWN_DATA;
        end else if (grant_en && (req != 2'b00)) begin
            prio_r <= grant[GNT_INST] ? OWN_DATA : OWN_INST;
        end else begin
            prio_r <= prio_r;
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like slave port between the instruction-fetch and
// data requesters, one outstanding transaction at a time.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic              i_wr,
    input  logic [1:0]        i_size,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              i_addr_ok,
    output logic              i_data_ok,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_addr_ok,
    output logic              d_data_ok,
    output logic [DATA_W-1:0] d_rdata,
    output logic              req,
    output logic              wr,
    output logic [1:0]        size,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wdata,
    input  logic              addr_ok,
    input  logic              data_ok,
    input  logic [DATA_W-1:0] rdata
);

    state_t     state_r;
    state_t     state_next_s;
    owner_t     owner_r;
    owner_t     owner_next_s;
    logic       any_req_s;
    logic       grant_en_s;
    logic [1:0] grant_s;

    assign any_req_s  = i_req | d_req;
    // Arbitrate in IDLE and on the closing data_ok so back-to-back requests see no bubble
    assign grant_en_s = (state_r == ST_IDLE) || ((state_r == ST_DATA) && data_ok);

    sram_like_arbiter_rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .resetn   (resetn),
        .req      ({d_req, i_req}),
        .grant_en (grant_en_s),
        .grant    (grant_s)
    );

    // State and owner registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_INST;
        end else begin
            state_r <= state_next_s;
            owner_r <= owner_next_s;
        end
    end

    // Next-state logic; data_ok is ignored while waiting for addr_ok
    always_comb begin
        state_next_s = state_r;
        owner_next_s = owner_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    state_next_s = ST_ADDR;
                    owner_next_s = grant_to_owner(grant_s);
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (addr_ok) begin
                    state_next_s = ST_DATA;
                end else begin
                    state_next_s = ST_ADDR;
                end
            end
            ST_DATA: begin
                if (data_ok && any_req_s) begin
                    state_next_s = ST_ADDR;
                    owner_next_s = grant_to_owner(grant_s);
                end else if (data_ok) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DATA;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                owner_next_s = OWN_INST;
            end
        endcase
    end

    // Request mux towards the slave and handshake demux back to the owner
    always_comb begin
        req       = 1'b0;
        wr        = 1'b0;
        size      = SIZE_BYTE;
        addr      = {ADDR_W{1'b0}};
        wdata     = {DATA_W{1'b0}};
        i_addr_ok = 1'b0;
        i_data_ok = 1'b0;
        d_addr_ok = 1'b0;
        d_data_ok = 1'b0;
        case (state_r)
            ST_ADDR: begin
                req = 1'b1;
                if (owner_r == OWN_DATA) begin
                    wr        = d_wr;
                    size      = d_size;
                    addr      = d_addr;
                    wdata     = d_wdata;
                    d_addr_ok = addr_ok;
                end else begin
                    wr        = i_wr;
                    size      = i_size;
                    addr      = i_addr;
                    wdata     = i_wdata;
                    i_addr_ok = addr_ok;
                end
            end
            ST_DATA: begin
                if (owner_r == OWN_DATA) begin
                    d_data_ok = data_ok;
                end else begin
                    i_data_ok = data_ok;
                end
            end
            default: begin
                req = 1'b0;
            end
        endcase
    end

    assign i_rdata = rdata;
    assign d_rdata = rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench for sram_like_arbiter: a per-cycle vector table for the
// single-read and tie cases, then hand-written multi-cycle sequences.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    localparam logic [31:0] IA = 32'hBFC0_0000;
    localparam logic [31:0] DA = 32'h8000_0002;
    localparam logic [31:0] RD = 32'h3C1D_0000;

    logic        clk;
    logic        resetn;
    logic        i_req, i_wr, d_req, d_wr;
    logic [1:0]  i_size, d_size, size;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    int tests;
    int failed;

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_wr(i_wr), .i_size(i_size), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rn, ir, dr, aok, dok;
        logic        e_req, e_iaok, e_idok, e_daok, e_ddok;
        logic [31:0] e_addr;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rn, input logic ir, input logic dr,
                         input logic aok, input logic dok);
        resetn  = rn;
        i_req   = ir;
        d_req   = dr;
        addr_ok = aok;
        data_ok = dok;
        #1;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_oks(input string name, input logic iaok, input logic idok,
                           input logic daok, input logic ddok);
        chk({name, ".i_addr_ok"}, 32'(i_addr_ok), 32'(iaok));
        chk({name, ".i_data_ok"}, 32'(i_data_ok), 32'(idok));
        chk({name, ".d_addr_ok"}, 32'(d_addr_ok), 32'(daok));
        chk({name, ".d_data_ok"}, 32'(d_data_ok), 32'(ddok));
    endtask

    int n_i, n_d;
    logic exp_d;

    initial begin
        tests   = 0;
        failed  = 0;
        i_wr    = 1'b0;
        i_size  = SIZE_WORD;
        i_addr  = IA;
        i_wdata = 32'h1234_5678;
        d_wr    = 1'b1;
        d_size  = SIZE_HALF;
        d_addr  = DA;
        d_wdata = 32'h0000_BEEF;
        rdata   = RD;

        //              rn ir dr ak dk | req iak idk dak ddk addr
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,1'b0,1'b0, IA};
        vecs[2]  = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, IA};
        vecs[3]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0};
        vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[8]  = '{1'b1,1'b1,1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0};
        vecs[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b0, 1'b1,1'b0,1'b0,1'b1,1'b0, DA};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b0, 1'b1,1'b1,1'b0,1'b0,1'b0, IA};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0};

        // Reset, with slave handshakes forced high to prove they are not forwarded
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick;
        tick;
        chk("rst.req", 32'(req), 32'd0);
        chk("rst.wr", 32'(wr), 32'd0);
        chk("rst.size", 32'(size), 32'd0);
        chk("rst.addr", addr, 32'd0);
        chk("rst.wdata", wdata, 32'd0);
        chk_oks("rst", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single read, reset, then a tie with back-to-back inst grant
        for (int k = 0; k < 13; k++) begin
            drive(vecs[k].rn, vecs[k].ir, vecs[k].dr, vecs[k].aok, vecs[k].dok);
            chk($sformatf("vec%0d.req", k), 32'(req), 32'(vecs[k].e_req));
            chk($sformatf("vec%0d.addr", k), addr, vecs[k].e_addr);
            chk_oks($sformatf("vec%0d", k), vecs[k].e_iaok, vecs[k].e_idok,
                    vecs[k].e_daok, vecs[k].e_ddok);
            if (vecs[k].e_idok) chk($sformatf("vec%0d.i_rdata", k), i_rdata, RD);
            tick;
        end

        // Sustained contention: eight transactions alternating D,I,D,I...
        n_i = 0;
        n_d = 0;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("rr.idle_req", 32'(req), 32'd0);
        tick;
        for (int t = 0; t < 8; t++) begin
            exp_d = ((t % 2) == 0);
            drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
            chk($sformatf("rr%0d.req", t), 32'(req), 32'd1);
            chk($sformatf("rr%0d.addr", t), addr, exp_d ? DA : IA);
            chk_oks($sformatf("rr%0d.a", t), ~exp_d, 1'b0, exp_d, 1'b0);
            if (d_addr_ok) n_d++;
            if (i_addr_ok) n_i++;
            tick;
            drive(1'b1, (t < 7), (t < 7), 1'b0, 1'b1);
            chk_oks($sformatf("rr%0d.d", t), 1'b0, ~exp_d, 1'b0, exp_d);
            tick;
        end
        chk("rr.n_inst", 32'(n_i), 32'd4);
        chk("rr.n_data", 32'(n_d), 32'd4);

        // Write passthrough
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("wr.idle_req", 32'(req), 32'd0);
        tick;
        for (int a = 0; a < 2; a++) begin
            drive(1'b1, 1'b0, 1'b1, (a == 1), 1'b0);
            chk($sformatf("wr%0d.req", a), 32'(req), 32'd1);
            chk($sformatf("wr%0d.wr", a), 32'(wr), 32'd1);
            chk($sformatf("wr%0d.size", a), 32'(size), 32'(SIZE_HALF));
            chk($sformatf("wr%0d.addr", a), addr, DA);
            chk($sformatf("wr%0d.wdata", a), wdata, 32'h0000_BEEF);
            chk($sformatf("wr%0d.d_addr_ok", a), 32'(d_addr_ok), 32'(a == 1));
            tick;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("wr.req_fall", 32'(req), 32'd0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_oks("wr.done", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("wr.d_rdata", d_rdata, RD);
        tick;

        // Reset during DATA: data granted (prio now inst), reset, then tie
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("rd.d_addr_ok", 32'(d_addr_ok), 32'd1);
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rd.req", 32'(req), 32'd0);
        chk_oks("rd.stale", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("rd.tie_addr", addr, DA);
        chk_oks("rd.tie", 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk_oks("rd.tie_done", 1'b0, 1'b0, 1'b0, 1'b1);
        tick;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        chk("rd.i_addr", addr, IA);
        chk_oks("rd.i_a", 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_oks("rd.i_d", 1'b0, 1'b1, 1'b0, 1'b0);
        tick;

        // Late data request while inst waits five cycles for addr_ok
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        for (int w = 0; w < 5; w++) begin
            drive(1'b1, 1'b1, (w >= 2), 1'b0, 1'b0);
            chk($sformatf("late%0d.req", w), 32'(req), 32'd1);
            chk($sformatf("late%0d.addr", w), addr, IA);
            chk($sformatf("late%0d.d_addr_ok", w), 32'(d_addr_ok), 32'd0);
            tick;
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        chk_oks("late.a", 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("late.data_req", 32'(req), 32'd0);
        chk_oks("late.wait", 1'b0, 1'b0, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk_oks("late.i_d", 1'b0, 1'b1, 1'b0, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("late.d_req", 32'(req), 32'd1);
        chk("late.d_addr", addr, DA);
        chk_oks("late.d_a", 1'b0, 1'b0, 1'b1, 1'b0);
        tick;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk_oks("late.d_d", 1'b0, 1'b0, 1'b0, 1'b1);
        tick;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
